// File: rtl/sld_capture_pkg.sv
// rtl/sld_capture_pkg.sv - shared state encoding and sizing helper for the capture sequencer
// Contents:
//   cap_state_e  2-bit capture state enum (IDLE=0 ARMED=1 POST=2 DONE=3)
//   STATE_*      the same encodings as plain logic [1:0] constants, used by the FSM
//   cnt_bits()   width of a counter that must hold 0..depth inclusive
package sld_capture_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE  = 2'd0,
    CAP_ARMED = 2'd1,
    CAP_POST  = 2'd2,
    CAP_DONE  = 2'd3
  } cap_state_e;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_ARMED = 2'd1;
  localparam logic [1:0] STATE_POST  = 2'd2;
  localparam logic [1:0] STATE_DONE  = 2'd3;

  function automatic int cnt_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sld_capture_sequencer_if.sv
// rtl/sld_capture_sequencer_if.sv - control/recorder bundle between design side and capture sequencer
// Parameters: DATA_BITS (sampled width), OUT_BITS (recorder word width), CNT_BITS (sample_count width)
// master: drives arm, abort, trig_cond, qual_in, data_in; observes recorder-side outputs
// slave : the sequencer; drives acq_data_out, acq_trigger_out, storage_enable, done, state_o, sample_count
interface sld_capture_sequencer_if #(
  parameter int DATA_BITS = 64,
  parameter int OUT_BITS  = 64,
  parameter int CNT_BITS  = 14
);

  logic                 arm;
  logic                 abort;
  logic                 trig_cond;
  logic                 qual_in;
  logic [DATA_BITS-1:0] data_in;
  logic [OUT_BITS-1:0]  acq_data_out;
  logic                 acq_trigger_out;
  logic                 storage_enable;
  logic                 done;
  logic [1:0]           state_o;
  logic [CNT_BITS-1:0]  sample_count;

  modport master (
    output arm, abort, trig_cond, qual_in, data_in,
    input  acq_data_out, acq_trigger_out, storage_enable, done, state_o, sample_count
  );

  modport slave (
    input  arm, abort, trig_cond, qual_in, data_in,
    output acq_data_out, acq_trigger_out, storage_enable, done, state_o, sample_count
  );

endinterface

// File: rtl/sld_trigger_detect.sv
// rtl/sld_trigger_detect.sv - trigger fire logic (edge or level) with arm-time history load
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   trig_cond   raw trigger condition
//   clear       arm accepted this cycle: history loads trig_cond so a level already high is not an edge
//   track       sequencer is ARMED (and not aborting): history follows trig_cond, fire may assert
//   fire        trigger detected this cycle (combinational)
module sld_trigger_detect #(
  parameter int SLD_TRIGGER_EDGE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_cond,
  input  logic clear,
  input  logic track,
  output logic fire
);

  logic trig_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_prev <= 1'b0;
    end else if (clear || track) begin
      trig_prev <= trig_cond;
    end
  end

  assign fire = track & ((SLD_TRIGGER_EDGE != 0) ? (trig_cond & ~trig_prev) : trig_cond);

endmodule

// File: rtl/sld_capture_sequencer.sv
// rtl/sld_capture_sequencer.sv - arm/pre-trigger/trigger/post-trigger acquisition controller for the recorder
// Optional feature macro: SLD_CAPTURE_TIMESTAMP_EN (prepends a free-running SLD_TS_BITS cycle stamp to each word)
// Ports:
//   acq_clk    clock; outputs update on posedge so the recorder can sample them on negedge
//   acq_rst_n  asynchronous active-low reset
//   bus        sld_capture_sequencer_if.slave: arm, abort, trig_cond, qual_in, data_in in;
//              acq_data_out, acq_trigger_out, storage_enable, done, state_o, sample_count out (all registered)
module sld_capture_sequencer
  import sld_capture_pkg::*;
#(
  parameter int SLD_DATA_BITS    = 64,
  parameter int SLD_SAMPLE_DEPTH = 8192,
  parameter int SLD_POST_DEPTH   = 4096,
  parameter int SLD_TRIGGER_EDGE = 1,
  parameter int SLD_TS_BITS      = 32
) (
  input  logic acq_clk,
  input  logic acq_rst_n,
  sld_capture_sequencer_if.slave bus
);

`ifdef SLD_CAPTURE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int OUT_BITS  = SLD_DATA_BITS + (TS_EN ? SLD_TS_BITS : 0);
  localparam int CNT_BITS  = cnt_bits(SLD_SAMPLE_DEPTH);
  // Pre-trigger window leaves room for the trigger sample and the full post window.
  localparam int PRE_MAX   = SLD_SAMPLE_DEPTH - SLD_POST_DEPTH - 1;
  localparam int POST_LAST = (SLD_POST_DEPTH > 0) ? SLD_POST_DEPTH - 1 : 0;

  logic [1:0]          state;
  logic [CNT_BITS-1:0] pre_cnt;
  logic [CNT_BITS-1:0] post_cnt;
  logic [CNT_BITS-1:0] sample_count;
  logic [OUT_BITS-1:0] data_q;
  logic                trigger_q;
  logic                store_q;
  logic                done_q;
  logic [OUT_BITS-1:0] sample_word;

  logic arm_ok;
  logic track;
  logic fire;
  logic pre_room;
  logic post_last;
  logic store;

`ifdef SLD_CAPTURE_TIMESTAMP_EN
  logic [SLD_TS_BITS-1:0] ts;

  always_ff @(posedge acq_clk or negedge acq_rst_n) begin
    if (!acq_rst_n) begin
      ts <= '0;
    end else begin
      ts <= ts + SLD_TS_BITS'(1);
    end
  end

  // Stamp carries the counter value seen at the sampling edge, before it advances.
  assign sample_word = {ts, bus.data_in};
`else
  assign sample_word = bus.data_in;
`endif

  // abort outranks everything, including an arm on the same cycle.
  assign arm_ok    = ~bus.abort & bus.arm & ((state == STATE_IDLE) | (state == STATE_DONE));
  assign track     = ~bus.abort & (state == STATE_ARMED);
  assign pre_room  = (pre_cnt < CNT_BITS'(PRE_MAX));
  assign post_last = (post_cnt == CNT_BITS'(POST_LAST));

  // The trigger sample is kept regardless of qualifier or window; a qualified
  // sample on the fire cycle is that same sample, so it is stored only once.
  assign store = (track & (fire | (bus.qual_in & pre_room))) |
                 (~bus.abort & (state == STATE_POST) & bus.qual_in);

  sld_trigger_detect #(
    .SLD_TRIGGER_EDGE(SLD_TRIGGER_EDGE)
  ) u_trigger_detect (
    .clk      (acq_clk),
    .rst_n    (acq_rst_n),
    .trig_cond(bus.trig_cond),
    .clear    (arm_ok),
    .track    (track),
    .fire     (fire)
  );

  always_ff @(posedge acq_clk or negedge acq_rst_n) begin
    if (!acq_rst_n) begin
      state        <= STATE_IDLE;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      sample_count <= '0;
      data_q       <= '0;
      trigger_q    <= 1'b0;
      store_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      store_q   <= store;
      trigger_q <= track & fire;
      if (store) begin
        data_q       <= sample_word;
        sample_count <= sample_count + CNT_BITS'(1);
      end

      if (bus.abort) begin
        state  <= STATE_IDLE;
        done_q <= 1'b0;
      end else if (arm_ok) begin
        state        <= STATE_ARMED;
        done_q       <= 1'b0;
        sample_count <= '0;
        pre_cnt      <= '0;
        post_cnt     <= '0;
      end else if (track) begin
        if (fire) begin
          state  <= (SLD_POST_DEPTH == 0) ? STATE_DONE : STATE_POST;
          done_q <= (SLD_POST_DEPTH == 0);
        end else if (bus.qual_in && pre_room) begin
          pre_cnt <= pre_cnt + CNT_BITS'(1);
        end
      end else if ((state == STATE_POST) && bus.qual_in) begin
        post_cnt <= post_cnt + CNT_BITS'(1);
        if (post_last) begin
          state  <= STATE_DONE;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.acq_data_out    = data_q;
  assign bus.acq_trigger_out = trigger_q;
  assign bus.storage_enable  = store_q;
  assign bus.done            = done_q;
  assign bus.state_o         = state;
  assign bus.sample_count    = sample_count;

endmodule

// File: tb/tb_sld_capture_sequencer.sv
// tb/tb_sld_capture_sequencer.sv - randomized and directed self-checking bench for sld_capture_sequencer
module tb_sld_capture_sequencer;
  import sld_capture_pkg::*;

  localparam int DB    = 16;
  localparam int TSB   = 4;
  localparam int DEPTH = 16;
`ifdef SLD_CAPTURE_TIMESTAMP_EN
  localparam int OB = DB + TSB;
`else
  localparam int OB = DB;
`endif
  localparam int CB = cnt_bits(DEPTH);
  localparam int VW = OB + 5 + CB;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          arm   = 1'b0;
  logic          abort = 1'b0;
  logic          trig  = 1'b0;
  logic          qual  = 1'b0;
  logic [DB-1:0] din   = '0;

  int checks = 0;
  int errors = 0;

  sld_capture_sequencer_if #(.DATA_BITS(DB), .OUT_BITS(OB), .CNT_BITS(CB)) if_a ();
  sld_capture_sequencer_if #(.DATA_BITS(DB), .OUT_BITS(OB), .CNT_BITS(CB)) if_b ();

  assign if_a.arm = arm;  assign if_a.abort = abort; assign if_a.trig_cond = trig;
  assign if_a.qual_in = qual; assign if_a.data_in = din;
  assign if_b.arm = arm;  assign if_b.abort = abort; assign if_b.trig_cond = trig;
  assign if_b.qual_in = qual; assign if_b.data_in = din;

  // dut_a: edge trigger, 4 post samples; dut_b: level trigger, no post samples
  sld_capture_sequencer #(
    .SLD_DATA_BITS(DB), .SLD_SAMPLE_DEPTH(DEPTH), .SLD_POST_DEPTH(4),
    .SLD_TRIGGER_EDGE(1), .SLD_TS_BITS(TSB)
  ) dut_a (.acq_clk(clk), .acq_rst_n(rst_n), .bus(if_a.slave));

  sld_capture_sequencer #(
    .SLD_DATA_BITS(DB), .SLD_SAMPLE_DEPTH(DEPTH), .SLD_POST_DEPTH(0),
    .SLD_TRIGGER_EDGE(0), .SLD_TS_BITS(TSB)
  ) dut_b (.acq_clk(clk), .acq_rst_n(rst_n), .bus(if_b.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 waiting for trigger, 2 collecting post samples, 3 finished
  int            m_phase[2];
  int            m_cnt[2];
  int            m_pre[2];
  int            m_post[2];
  bit            m_prev[2];
  bit            m_done[2];
  bit            m_se[2];
  bit            m_tr[2];
  logic [OB-1:0] m_data[2];
  int            m_ts;

  function automatic int post_of(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  function automatic bit edge_of(input int i);
    return (i == 0);
  endfunction

  task automatic model_keep(input int i, input logic [OB-1:0] w);
    m_se[i]   = 1'b1;
    m_data[i] = w;
    m_cnt[i]  = m_cnt[i] + 1;
  endtask

  task automatic model_step(input int i);
    bit            fired;
    logic [OB-1:0] w;
`ifdef SLD_CAPTURE_TIMESTAMP_EN
    w = {TSB'(m_ts), din};
`else
    w = din;
`endif
    m_se[i] = 1'b0;
    m_tr[i] = 1'b0;
    if (abort) begin
      m_phase[i] = 0;
      m_done[i]  = 1'b0;
    end else if (m_phase[i] == 0 || m_phase[i] == 3) begin
      if (arm) begin
        m_phase[i] = 1; m_done[i] = 1'b0;
        m_cnt[i] = 0; m_pre[i] = 0; m_post[i] = 0;
        m_prev[i] = trig;
      end
    end else if (m_phase[i] == 1) begin
      fired = edge_of(i) ? (trig && !m_prev[i]) : trig;
      m_prev[i] = trig;
      if (fired) begin
        model_keep(i, w);
        m_tr[i] = 1'b1;
        if (post_of(i) == 0) begin
          m_phase[i] = 3; m_done[i] = 1'b1;
        end else begin
          m_phase[i] = 2;
        end
      end else if (qual && m_pre[i] < DEPTH - post_of(i) - 1) begin
        model_keep(i, w);
        m_pre[i]++;
      end
    end else if (qual) begin
      model_keep(i, w);
      m_post[i]++;
      if (m_post[i] == post_of(i)) begin
        m_phase[i] = 3; m_done[i] = 1'b1;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_phase[i] = 0; m_cnt[i] = 0; m_pre[i] = 0; m_post[i] = 0;
        m_prev[i] = 1'b0; m_done[i] = 1'b0; m_se[i] = 1'b0; m_tr[i] = 1'b0;
        m_data[i] = '0;
      end
      m_ts = 0;
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
      m_ts = (m_ts + 1) % (1 << TSB);
    end
  end

  function automatic logic [VW-1:0] exp_v(input int i);
    logic [1:0]    st;
    logic [CB-1:0] c;
    st = 2'(m_phase[i]);
    c  = CB'(m_cnt[i]);
    return {m_data[i], m_tr[i], m_se[i], m_done[i], st, c};
  endfunction

  logic [VW-1:0] act_v[2];
  assign act_v[0] = {if_a.acq_data_out, if_a.acq_trigger_out, if_a.storage_enable,
                     if_a.done, if_a.state_o, if_a.sample_count};
  assign act_v[1] = {if_b.acq_data_out, if_b.acq_trigger_out, if_b.storage_enable,
                     if_b.done, if_b.state_o, if_b.sample_count};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) chk($sformatf("reset_outputs_dut%0d", i), 64'(act_v[i]), 64'(0));
      else        chk($sformatf("cycle_dut%0d", i), 64'(act_v[i]), 64'(exp_v(i)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit a, input bit ab, input bit t, input bit q);
    arm = a; abort = ab; trig = t; qual = q;
    din = DB'($urandom);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // 11 pre + trigger at cycle 20 + 4 post fills the 16-deep capture
    step(1, 0, 0, 1);
    for (int k = 1; k < 20; k++) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    chk("a_trigger_flag", 64'(if_a.acq_trigger_out), 64'(1));
    chk("a_count_at_trigger", 64'(if_a.sample_count), 64'(12));
    chk("a_state_post", 64'(if_a.state_o), 64'(2));
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1);
    chk("a_full_count", 64'(if_a.sample_count), 64'(16));
    chk("a_done_level", 64'(if_a.done), 64'(1));
    chk("a_state_done", 64'(if_a.state_o), 64'(3));
    step(0, 0, 0, 1);
    chk("a_no_store_after_done", 64'(if_a.storage_enable), 64'(0));

    // abort together with arm while in POST
    step(1, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("a_post_count", 64'(if_a.sample_count), 64'(2));
    step(1, 1, 0, 1);
    chk("a_abort_no_store", 64'(if_a.storage_enable), 64'(0));
    chk("a_abort_idle", 64'(if_a.state_o), 64'(0));
    step(1, 0, 0, 0);
    chk("a_rearm_count", 64'(if_a.sample_count), 64'(0));
    chk("a_rearm_state", 64'(if_a.state_o), 64'(1));

    // edge mode: level already high at arm must not fire
    step(0, 1, 0, 0);
    step(1, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 0);
      chk("a_held_level_no_fire", 64'({if_a.acq_trigger_out, if_a.storage_enable}), 64'(0));
    end
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("a_edge_fire", 64'({if_a.acq_trigger_out, if_a.storage_enable}), 64'(3));
    chk("a_edge_count", 64'(if_a.sample_count), 64'(1));

    // zero post depth: unqualified trigger is the only stored sample
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
    chk("b_nothing_unqualified", 64'(if_b.sample_count), 64'(0));
    step(0, 0, 1, 0);
    chk("b_trigger_store", 64'({if_b.acq_trigger_out, if_b.storage_enable, if_b.done}), 64'(7));
    chk("b_single_sample", 64'(if_b.sample_count), 64'(1));
    chk("b_state_done", 64'(if_b.state_o), 64'(3));
    step(0, 0, 0, 1);
    chk("b_done_no_store", 64'(if_b.storage_enable), 64'(0));
    chk("b_count_held", 64'(if_b.sample_count), 64'(1));

    // asynchronous reset while collecting post samples
    step(0, 1, 0, 0);
    step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    chk("a_pre_reset_post", 64'(if_a.state_o), 64'(2));
    rst_n = 1'b0;
    #1;
    chk("a_async_reset_zero", 64'(act_v[0]), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(0, 0, 0, 0);
    chk("a_idle_after_reset", 64'(if_a.state_o), 64'(0));
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("a_first_store_after_reset", 64'(if_a.sample_count), 64'(1));
`ifdef SLD_CAPTURE_TIMESTAMP_EN
    chk("a_ts_after_reset", 64'(if_a.acq_data_out[OB-1:DB]), 64'(2));
`endif

    // randomized traffic checked cycle by cycle against the model
    for (int k = 0; k < 2500; k++) begin
      step($urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
